// File: rtl/imsic_msi_dispatch.sv
// imsic_msi_dispatch
//   Shares the single MSI delivery path towards the per-hart IMSIC CSR gates
//   between NR_REQ requesters. Requesters are served round-robin. Each accepted
//   MSI becomes one delivery pulse: o_msi_info_vld is high for VLD_HIGH_CYC
//   cycles, then o_msi_info is held stable for INFO_HOLD_CYC more cycles. This
//   lets the gates synchronise vld and latch info on the synced falling edge.
//
// Ports
//   clk             in   clock
//   rst             in   synchronous reset, active-high
//   i_req_vld       in   [NR_REQ]      requester k has an MSI pending
//   i_req_info      in   [NR_REQ*W]    requester k info at [k*W +: W]
//   o_req_rdy       out  [NR_REQ]      one-hot accept strobe (combinational)
//   o_msi_info      out  [W]           registered info to the IMSIC gates
//   o_msi_info_vld  out  1             registered delivery pulse
//   o_busy          out  1             high whenever a pulse is in progress
module imsic_msi_dispatch #(
  parameter int NR_REQ         = 2,
  parameter int MSI_INFO_WIDTH = 17,
  parameter int VLD_HIGH_CYC   = 5,
  parameter int INFO_HOLD_CYC  = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NR_REQ-1:0]                i_req_vld,
  input  logic [NR_REQ*MSI_INFO_WIDTH-1:0] i_req_info,
  output logic [NR_REQ-1:0]                o_req_rdy,
  output logic [MSI_INFO_WIDTH-1:0]        o_msi_info,
  output logic                             o_msi_info_vld,
  output logic                             o_busy
);

  localparam int REQ_WIDTH = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int MAX_CYC   = (VLD_HIGH_CYC > INFO_HOLD_CYC) ? VLD_HIGH_CYC : INFO_HOLD_CYC;
  localparam int CNT_WIDTH = $clog2(MAX_CYC + 1);

  if (VLD_HIGH_CYC < 1 || INFO_HOLD_CYC < 1) begin : g_bad_param
    $error("imsic_msi_dispatch: VLD_HIGH_CYC and INFO_HOLD_CYC must both be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [REQ_WIDTH-1:0]      rr_ptr;
  logic [REQ_WIDTH-1:0]      rr_ptr_nxt;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [CNT_WIDTH-1:0]      cnt_nxt;
  logic [MSI_INFO_WIDTH-1:0] info;
  logic [MSI_INFO_WIDTH-1:0] info_nxt;
  logic                      vld;
  logic                      vld_nxt;
  logic [NR_REQ-1:0]         rdy;

  logic                      grant_found;
  logic [REQ_WIDTH-1:0]      grant_idx;
  logic [REQ_WIDTH-1:0]      cand;
  logic [MSI_INFO_WIDTH-1:0] grant_info;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NR_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = {REQ_WIDTH{1'b0}};
    cand        = {REQ_WIDTH{1'b0}};
    for (int i = 0; i < NR_REQ; i++) begin
      cand = REQ_WIDTH'((int'(rr_ptr) + i) % NR_REQ);
      if (!grant_found && i_req_vld[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end else begin
        grant_found = grant_found;
      end
    end
    grant_info = i_req_info[grant_idx*MSI_INFO_WIDTH +: MSI_INFO_WIDTH];
  end

  // Next-state, counter, pulse and accept-strobe logic for IDLE -> HIGH -> HOLD -> IDLE.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    info_nxt   = info;
    vld_nxt    = vld;
    rdy        = {NR_REQ{1'b0}};
    case (state)
      IDLE: begin
        // rst gates the strobe so no requester believes it was accepted during reset
        if (grant_found && !rst) begin
          rdy[grant_idx] = 1'b1;
          info_nxt       = grant_info;
          vld_nxt        = 1'b1;
          rr_ptr_nxt     = REQ_WIDTH'((int'(grant_idx) + 1) % NR_REQ);
          cnt_nxt        = CNT_WIDTH'(1);
          state_nxt      = HIGH;
        end else begin
          vld_nxt = 1'b0;
        end
      end
      HIGH: begin
        if (cnt == CNT_WIDTH'(VLD_HIGH_CYC)) begin
          vld_nxt   = 1'b0;
          cnt_nxt   = CNT_WIDTH'(1);
          state_nxt = HOLD;
        end else begin
          vld_nxt = 1'b1;
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      HOLD: begin
        vld_nxt = 1'b0;
        if (cnt == CNT_WIDTH'(INFO_HOLD_CYC)) begin
          cnt_nxt   = CNT_WIDTH'(0);
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        vld_nxt   = 1'b0;
        cnt_nxt   = CNT_WIDTH'(0);
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any pulse in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= {REQ_WIDTH{1'b0}};
      cnt    <= CNT_WIDTH'(0);
      info   <= {MSI_INFO_WIDTH{1'b0}};
      vld    <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      cnt    <= cnt_nxt;
      info   <= info_nxt;
      vld    <= vld_nxt;
    end
  end

  assign o_req_rdy      = rdy;
  assign o_msi_info     = info;
  assign o_msi_info_vld = vld;
  assign o_busy         = (state != IDLE);

endmodule

// File: tb/tb_imsic_msi_dispatch.sv
// tb_imsic_msi_dispatch
//   Directed scenarios (single, contention, info stability, withdraw, reset
//   mid-pulse) followed by randomized requester traffic. Expected outputs come
//   from a timeline model: the cycle of the last accept and the cycle the path
//   becomes free again determine vld/busy; the round-robin pointer and the
//   latched info are tracked as plain integers.
module tb_imsic_msi_dispatch;

  localparam int N  = 2;
  localparam int W  = 17;
  localparam int VH = 5;
  localparam int IH = 6;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_info;
  logic [N-1:0]   req_rdy;
  logic [W-1:0]   msi_info;
  logic           msi_info_vld;
  logic           busy;

  imsic_msi_dispatch #(
    .NR_REQ(N), .MSI_INFO_WIDTH(W), .VLD_HIGH_CYC(VH), .INFO_HOLD_CYC(IH)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_vld(req_vld), .i_req_info(req_info),
    .o_req_rdy(req_rdy), .o_msi_info(msi_info),
    .o_msi_info_vld(msi_info_vld), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int         cyc        = 0;
  int         free_at    = 0;
  int         acc_cyc    = -1000;
  int         rr         = 0;
  logic [W-1:0] m_info   = '0;
  int         last_grant = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // one clock cycle: compare outputs mid-cycle, advance the model, cross the edge
  task automatic step();
    logic [N-1:0] exp_rdy;
    logic         exp_vld;
    logic         exp_busy;
    int           grant;
    @(negedge clk);
    exp_busy = (cyc < free_at);
    exp_vld  = (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + VH);
    exp_rdy  = '0;
    grant    = -1;
    if (!rst && !exp_busy) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (rr + i) % N;
        if (grant < 0 && req_vld[k]) grant = k;
      end
    end
    if (grant >= 0) exp_rdy[grant] = 1'b1;
    check_eq("rdy",  32'(req_rdy),      32'(exp_rdy));
    check_eq("vld",  32'(msi_info_vld), 32'(exp_vld));
    check_eq("info", 32'(msi_info),     32'(m_info));
    check_eq("busy", 32'(busy),         32'(exp_busy));
    if (rst) begin
      m_info  = '0;
      free_at = cyc + 1;
      acc_cyc = -1000;
      rr      = 0;
    end else if (grant >= 0) begin
      m_info  = req_info[grant*W +: W];
      acc_cyc = cyc;
      free_at = cyc + 1 + VH + IH;
      rr      = (grant + 1) % N;
    end
    last_grant = grant;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic set_info(input int k, input logic [W-1:0] v);
    req_info[k*W +: W] = v;
  endtask

  initial begin
    rst      = 1'b1;
    req_vld  = '0;
    req_info = '0;
    @(posedge clk);
    #1;
    // reset state checked while rst is still held
    do_reset(2);

    // single request from requester 0
    set_info(0, 17'h0_0005);
    req_vld = 2'b01;
    step();
    req_vld = 2'b00;
    repeat (13) step();

    // contention: both held continuously, grants must alternate 0,1,0,1
    do_reset(1);
    set_info(0, 17'h1_aaaa);
    set_info(1, 17'h0_5555);
    req_vld = 2'b11;
    repeat (48) step();
    req_vld = 2'b00;
    repeat (12) step();

    // info stability: requester 0 changes info one cycle after accept
    do_reset(1);
    set_info(0, 17'h0_1234);
    req_vld = 2'b01;
    step();
    set_info(0, 17'h1_4321);
    repeat (24) step();
    req_vld = 2'b00;
    repeat (12) step();

    // withdraw: requester 1 valid 3 cycles inside the busy window, then drops
    do_reset(1);
    set_info(0, 17'h0_0042);
    set_info(1, 17'h1_0099);
    req_vld = 2'b01;
    step();
    req_vld = 2'b00;
    repeat (2) step();
    req_vld = 2'b10;
    repeat (3) step();
    req_vld = 2'b00;
    repeat (6) step();
    set_info(0, 17'h0_0077);
    req_vld = 2'b01;
    step();
    req_vld = 2'b00;
    repeat (12) step();

    // reset in the middle of the vld pulse
    do_reset(1);
    set_info(0, 17'h0_0abc);
    set_info(1, 17'h1_0def);
    req_vld = 2'b11;
    step();
    req_vld = 2'b00;
    repeat (2) step();
    set_info(0, 17'h0_0111);
    req_vld = 2'b01;
    rst     = 1'b1;
    step();
    rst     = 1'b0;
    step();
    req_vld = 2'b00;
    repeat (12) step();

    // randomized traffic with withdrawals and occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req_vld[k] && last_grant == k) begin
          req_vld[k] = 1'($urandom % 2);
          set_info(k, W'($urandom));
        end else if (!req_vld[k]) begin
          if ($urandom % 4 == 0) begin
            req_vld[k] = 1'b1;
            set_info(k, W'($urandom));
          end
        end else if ($urandom % 16 == 0) begin
          req_vld[k] = 1'b0;
        end
      end
      rst = ($urandom % 300 == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
